sudoku_propagation_solver: RTL and testbench
============================================

SUDOKU_PROPAGATION_SOLVER -- requirements
Module: sudoku_propagation_solver

Interface
REQ-001 SHALL have parameter BOX, default 3: box edge; grid edge N = BOX*BOX.
REQ-002 SHALL have parameter DW, default 4: digit width; DW >= clog2(N+1).
REQ-003 SHALL have parameter ITER_W, default 8: width of the sweep counter.
REQ-004 SHALL have port clk_in, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset_in, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start_in, input, 1: begin solve; sampled only when idle.
REQ-007 SHALL have port board_in, input, DW*N*N: puzzle; cell (r,c) at bits [(r*N+c)*DW +: DW]; 0 = blank, 1..N = given.
REQ-008 SHALL have port board_out, output, DW*N*N: current board, same packing; 0 = unresolved cell.
REQ-009 SHALL have port busy_out, output, 1: solve in progress.
REQ-010 SHALL have port done_out, output, 1: one-cycle completion pulse.
REQ-011 SHALL have ports solved_out, conflict_out and stuck_out, output, 1 each: final status, held until next accepted start.
REQ-012 SHALL have port iter_out, output, ITER_W: sweeps performed in the current/last solve.

Function
REQ-013 SHALL store one N-bit candidate mask per cell; states IDLE, PROP, DONE.
REQ-014 IDLE: start_in=1 at an edge SHALL load masks (given v -> bit v-1 set; blank -> all ones; value > N -> mask 0), clear status and iter, set busy_out, and enter PROP.
REQ-015 PROP: each edge SHALL perform one sweep and increment iter_out: for every cell with more than one candidate, remove every digit held by a single-candidate cell in the same row, column or box.
REQ-016 Conflict SHALL be flagged when any post-sweep mask is 0, or when two single-candidate cells in one unit hold the same digit.
REQ-017 Sweep outcome priority SHALL be: conflict -> conflict_out=1; else all masks singletons -> solved_out=1; else no mask changed -> stuck_out=1; else iter_out reaches 2^ITER_W-1 -> stuck_out=1; else stay in PROP.
REQ-018 Any terminal outcome SHALL, on the same edge, enter DONE, clear busy_out and assert done_out for exactly one cycle.
REQ-019 Exactly one of solved_out, conflict_out and stuck_out SHALL be 1 in DONE.
REQ-020 DONE SHALL behave as IDLE for start_in, so back-to-back solves are allowed.
REQ-021 start_in while busy_out=1 SHALL be ignored; board_in is sampled only on the accepting edge.
REQ-022 board_out SHALL be registered: a cell shows digit v when its mask is the singleton bit v-1, else 0; it is valid in PROP and DONE.
REQ-023 A fully given valid board SHALL finish in 1 sweep, with done_out high in the cycle after the second edge following start.

Reset
REQ-024 reset_in=0 SHALL, immediately and at any time including mid-PROP, force IDLE, all masks 0, and every output 0.
REQ-025 The first start_in SHALL be honoured on the first edge after reset_in rises.

Structure
REQ-026 Package sudoku_pkg SHALL hold the state enum, the one-hot encode/decode functions (parametrised by N), and the clog2 helper.
REQ-027 Per-cell update (own mask plus row/column/box fixed-digit OR -> next mask, changed flag, conflict flag) SHALL be sub-module sudoku_cell_update, instanced N*N times by generate.
REQ-028 Unit OR-reductions SHALL be combinational; masks, status and iter SHALL be the only state.

Verification
REQ-029 Fully given valid 9x9 board, start -> done_out pulse in the cycle after the second edge after start, solved_out=1, iter_out=1, board_out==board_in.
REQ-030 Valid 9x9 solution with cell (0,0) blanked (true value 5) -> solved_out=1, iter_out=1, board_out cell(0,0)=5.
REQ-031 Row 0 with given 7 at (0,0) and (0,4) -> conflict_out=1, iter_out=1, solved_out=0.
REQ-032 All-zero board -> stuck_out=1, iter_out=1, board_out all 0.
REQ-033 Reset pulse during PROP of an easy puzzle -> busy_out=0, done_out=0, board_out=0 with no clock edge; a new start completes normally.
REQ-034 BOX=2 instance, 4x4 solution with two blanks -> solved_out=1; a second start_in issued while busy -> no effect on result or iter_out.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the constraint-propagation Sudoku solver.
package sudoku_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StProp = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2; used to size digit fields (DW >= sudoku_clog2(N + 1)).
  function automatic int unsigned sudoku_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Digit 1..n -> bit (digit-1); anything else -> empty mask.
  function automatic logic [31:0] onehot_encode(input int unsigned digit, input int unsigned n);
    logic [31:0] m;
    m = '0;
    if (digit >= 1 && digit <= n) m = 32'(1) << (digit - 1);
    return m;
  endfunction

  // Singleton mask over the low n bits -> its digit; otherwise 0.
  function automatic int unsigned onehot_decode(input logic [31:0] mask, input int unsigned n);
    int unsigned cnt;
    int unsigned val;
    cnt = 0;
    val = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (mask[i]) begin
        cnt++;
        val = i + 1;
      end
    end
    return (cnt == 1) ? val : 0;
  endfunction

endpackage

// File: rtl/sudoku_cell_update.sv
// One-sweep update of a single cell's candidate mask from the fixed digits
// held by the other cells of its row, column and box.
module sudoku_cell_update #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] mask,
  input  logic [N-1:0] row_fix,
  input  logic [N-1:0] col_fix,
  input  logic [N-1:0] box_fix,
  output logic [N-1:0] next_mask,
  output logic         changed,
  output logic         conflict
);

  logic [N-1:0] taken;
  logic         single;

  // Prune a multi-candidate cell; a fixed cell keeps its digit and flags a clash.
  always_comb begin
    taken  = row_fix | col_fix | box_fix;
    single = (mask != '0) && ((mask & (mask - N'(1))) == '0);
    if (single) begin
      next_mask = mask;
      conflict  = |(mask & taken);
    end else begin
      next_mask = mask & ~taken;
      conflict  = (next_mask == '0);
    end
    changed = (next_mask != mask);
  end

endmodule

// File: rtl/sudoku_propagation_solver.sv
// Iterative constraint-propagation Sudoku solver: one full-board sweep per clock
// until the board is solved, contradicts itself, or stops making progress.
module sudoku_propagation_solver
  import sudoku_pkg::*;
#(
  parameter int unsigned BOX    = 3,
  parameter int unsigned DW     = 4,
  parameter int unsigned ITER_W = 8,
  localparam int unsigned N     = BOX * BOX
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [DW*N*N-1:0] board_in,
  output logic [DW*N*N-1:0] board_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              solved_out,
  output logic              conflict_out,
  output logic              stuck_out,
  output logic [ITER_W-1:0] iter_out
);

  localparam int unsigned CELLS = N * N;
  localparam logic [ITER_W-1:0] IterMax = '1;

  state_e            state_q;
  logic [N-1:0]      mask_q    [CELLS];
  logic [N-1:0]      load_mask [CELLS];
  logic [N-1:0]      fix       [CELLS];
  logic [N-1:0]      row_or    [CELLS];
  logic [N-1:0]      col_or    [CELLS];
  logic [N-1:0]      box_or    [CELLS];
  logic [N-1:0]      next_mask [CELLS];
  logic [CELLS-1:0]  cell_chg;
  logic [CELLS-1:0]  cell_conf;
  logic              solved_q, conflict_q, stuck_q, done_q;
  logic [ITER_W-1:0] iter_q, iter_next;
  logic              sweep_solved, sweep_stuck, sweep_end;

  // Translate the packed puzzle into initial candidate masks.
  always_comb begin
    for (int unsigned i = 0; i < CELLS; i++) begin
      int unsigned d;
      d = 32'(board_in[i*DW +: DW]);
      load_mask[i] = (d == 0) ? '1 : N'(onehot_encode(d, N));
    end
  end

  // Fixed digit of each singleton cell, OR-ed per unit excluding the cell itself.
  always_comb begin
    for (int unsigned i = 0; i < CELLS; i++) begin
      fix[i] = (mask_q[i] != '0 && (mask_q[i] & (mask_q[i] - N'(1))) == '0) ? mask_q[i] : '0;
    end
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        row_or[r*N+c] = '0;
        col_or[r*N+c] = '0;
        box_or[r*N+c] = '0;
        for (int unsigned k = 0; k < N; k++) begin
          int unsigned br, bc;
          br = (r / BOX) * BOX + k / BOX;
          bc = (c / BOX) * BOX + k % BOX;
          if (k != c) row_or[r*N+c] = row_or[r*N+c] | fix[r*N+k];
          if (k != r) col_or[r*N+c] = col_or[r*N+c] | fix[k*N+c];
          if (br != r || bc != c) box_or[r*N+c] = box_or[r*N+c] | fix[br*N+bc];
        end
      end
    end
  end

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    sudoku_cell_update #(
      .N(N)
    ) u_cell (
      .mask     (mask_q[i]),
      .row_fix  (row_or[i]),
      .col_fix  (col_or[i]),
      .box_fix  (box_or[i]),
      .next_mask(next_mask[i]),
      .changed  (cell_chg[i]),
      .conflict (cell_conf[i])
    );
  end

  // Classify the outcome of the sweep in progress.
  always_comb begin
    iter_next    = iter_q + ITER_W'(1);
    sweep_solved = 1'b1;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (onehot_decode(32'(next_mask[i]), N) == 0) sweep_solved = 1'b0;
    end
    sweep_stuck = !(|cell_chg) || (iter_next == IterMax);
    sweep_end   = (|cell_conf) || sweep_solved || sweep_stuck;
  end

  // Solver state: masks, status flags and sweep counter.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= StIdle;
      for (int unsigned i = 0; i < CELLS; i++) mask_q[i] <= '0;
      solved_q   <= 1'b0;
      conflict_q <= 1'b0;
      stuck_q    <= 1'b0;
      done_q     <= 1'b0;
      iter_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start_in) begin
            for (int unsigned i = 0; i < CELLS; i++) mask_q[i] <= load_mask[i];
            solved_q   <= 1'b0;
            conflict_q <= 1'b0;
            stuck_q    <= 1'b0;
            iter_q     <= '0;
            state_q    <= StProp;
          end
        end
        StProp: begin
          for (int unsigned i = 0; i < CELLS; i++) mask_q[i] <= next_mask[i];
          iter_q <= iter_next;
          if (sweep_end) begin
            // Priority: conflict over solved over stuck.
            conflict_q <= |cell_conf;
            solved_q   <= !(|cell_conf) && sweep_solved;
            stuck_q    <= !(|cell_conf) && !sweep_solved;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Board view is a pure decode of the mask registers.
  always_comb begin
    board_out = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      board_out[i*DW +: DW] = DW'(onehot_decode(32'(mask_q[i]), N));
    end
  end

  assign busy_out     = (state_q == StProp);
  assign done_out     = done_q;
  assign solved_out   = solved_q;
  assign conflict_out = conflict_q;
  assign stuck_out    = stuck_q;
  assign iter_out     = iter_q;

endmodule

// File: tb/tb_sudoku_propagation_solver.sv
// Scoreboard bench for the propagation solver: a 9x9 and a 4x4 instance.
module tb_sudoku_propagation_solver;

  typedef struct {
    logic        solved;
    logic        conflict;
    logic        stuck;
    int unsigned iter;
    logic [323:0] board;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start9 = 1'b0, start4 = 1'b0;
  logic [323:0] board9_in = '0, board9_out;
  logic [63:0]  board4_in = '0, board4_out;
  logic         busy9, done9, solved9, conflict9, stuck9;
  logic         busy4, done4, solved4, conflict4, stuck4;
  logic [7:0]   iter9, iter4;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  exp_t exp9_q[$];
  exp_t exp4_q[$];

  int sol9 [81] = '{5,3,4,6,7,8,9,1,2,  6,7,2,1,9,5,3,4,8,  1,9,8,3,4,2,5,6,7,
                    8,5,9,7,6,1,4,2,3,  4,2,6,8,5,3,7,9,1,  7,1,3,9,2,4,8,5,6,
                    9,6,1,5,3,7,2,8,4,  2,8,7,4,1,9,6,3,5,  3,4,5,2,8,6,1,7,9};
  int sol4 [16] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};

  always #5 clk = ~clk;

  sudoku_propagation_solver #(.BOX(3), .DW(4), .ITER_W(8)) u_dut9 (
    .clk_in(clk), .reset_in(rst_n), .start_in(start9), .board_in(board9_in),
    .board_out(board9_out), .busy_out(busy9), .done_out(done9), .solved_out(solved9),
    .conflict_out(conflict9), .stuck_out(stuck9), .iter_out(iter9)
  );

  sudoku_propagation_solver #(.BOX(2), .DW(4), .ITER_W(8)) u_dut4 (
    .clk_in(clk), .reset_in(rst_n), .start_in(start4), .board_in(board4_in),
    .board_out(board4_out), .busy_out(busy4), .done_out(done4), .solved_out(solved4),
    .conflict_out(conflict4), .stuck_out(stuck4), .iter_out(iter4)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_board(input string name, input logic [323:0] act, input logic [323:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [323:0] pack9(input int g [81]);
    logic [323:0] b;
    b = '0;
    for (int i = 0; i < 81; i++) b[i*4 +: 4] = 4'(g[i]);
    return b;
  endfunction

  function automatic logic [63:0] pack4(input int g [16]);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i*4 +: 4] = 4'(g[i]);
    return b;
  endfunction

  function automatic exp_t mk(input logic s, input logic c, input logic st, input int unsigned it,
                              input logic [323:0] b);
    exp_t e;
    e.solved = s; e.conflict = c; e.stuck = st; e.iter = it; e.board = b;
    return e;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done9) begin
      if (exp9_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb9_unexpected: done_out=1 with no pending result");
      end else begin
        exp_t e;
        e = exp9_q.pop_front();
        chk("sb9_solved", 32'(solved9), 32'(e.solved));
        chk("sb9_conflict", 32'(conflict9), 32'(e.conflict));
        chk("sb9_stuck", 32'(stuck9), 32'(e.stuck));
        chk("sb9_iter", 32'(iter9), e.iter);
        chk("sb9_busy", 32'(busy9), 0);
        chk_board("sb9_board", board9_out, e.board);
      end
    end
    if (done4) begin
      if (exp4_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb4_unexpected: done_out=1 with no pending result");
      end else begin
        exp_t e;
        e = exp4_q.pop_front();
        chk("sb4_solved", 32'(solved4), 32'(e.solved));
        chk("sb4_conflict", 32'(conflict4), 32'(e.conflict));
        chk("sb4_stuck", 32'(stuck4), 32'(e.stuck));
        chk("sb4_iter", 32'(iter4), e.iter);
        chk_board("sb4_board", 324'(board4_out), e.board);
      end
    end
  end

  task automatic go9(input logic [323:0] b);
    @(negedge clk);
    board9_in = b;
    start9 = 1'b1;
    @(posedge clk);
    #1 start9 = 1'b0;
  endtask

  task automatic wait9(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done9) seen = 1'b1;
    end
    chk(name, 32'(seen), 1);
  endtask

  task automatic wait4(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    chk(name, 32'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g [81];
    int h [16];
    logic [323:0] full9, multi9, conf_b, conf_exp;

    full9 = pack9(sol9);
    #3;
    chk("rst_busy", 32'(busy9), 0);
    chk("rst_done", 32'(done9), 0);
    chk("rst_solved", 32'(solved9), 0);
    chk("rst_conflict", 32'(conflict9), 0);
    chk("rst_stuck", 32'(stuck9), 0);
    chk("rst_iter", 32'(iter9), 0);
    chk_board("rst_board", board9_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fully given board: done exactly after the second edge.
    exp9_q.push_back(mk(1'b1, 1'b0, 1'b0, 1, full9));
    go9(full9);
    chk("full_busy", 32'(busy9), 1);
    chk("full_done_early", 32'(done9), 0);
    @(posedge clk);
    #1 chk("full_done_latency", 32'(done9), 1);
    wait9("full_wait");

    // Single blank at (0,0), true value 5.
    g = sol9;
    g[0] = 0;
    exp9_q.push_back(mk(1'b1, 1'b0, 1'b0, 1, full9));
    go9(pack9(g));
    wait9("blank00_wait");

    // Two 7s in row 0, everything else blank.
    conf_b = '0;
    conf_b[0*4 +: 4] = 4'd7;
    conf_b[4*4 +: 4] = 4'd7;
    conf_exp = conf_b;
    exp9_q.push_back(mk(1'b0, 1'b1, 1'b0, 1, conf_exp));
    go9(conf_b);
    wait9("conflict_wait");

    // Empty board makes no progress.
    exp9_q.push_back(mk(1'b0, 1'b0, 1'b1, 1, '0));
    go9('0);
    wait9("empty_wait");

    // Two-sweep puzzle (row 0 and (1,0) blank), reset after the first sweep.
    g = sol9;
    for (int i = 0; i < 10; i++) g[i] = 0;
    multi9 = pack9(g);
    go9(multi9);
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy9), 1);
    chk("mid_cell01", 32'(board9_out[4 +: 4]), 3);
    chk("mid_cell00", 32'(board9_out[0 +: 4]), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy9), 0);
    chk("arst_done", 32'(done9), 0);
    chk("arst_stuck", 32'(stuck9), 0);
    chk("arst_iter", 32'(iter9), 0);
    chk_board("arst_board", board9_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp9_q.push_back(mk(1'b1, 1'b0, 1'b0, 2, full9));
    board9_in = multi9;
    start9 = 1'b1;
    @(posedge clk);
    #1 start9 = 1'b0;
    chk("post_rst_accept", 32'(busy9), 1);
    wait9("multi_wait");

    // 4x4: two blanks, start held and board changed while busy.
    h = sol4;
    h[0] = 0;
    h[15] = 0;
    exp4_q.push_back(mk(1'b1, 1'b0, 1'b0, 1, 324'(pack4(sol4))));
    @(negedge clk);
    board4_in = pack4(h);
    start4 = 1'b1;
    @(posedge clk);
    #1 board4_in = '0;
    @(posedge clk);
    #1 start4 = 1'b0;
    wait4("b2_busy_start_wait");

    // 4x4: two sweeps needed.
    h = sol4;
    for (int i = 0; i < 5; i++) h[i] = 0;
    exp4_q.push_back(mk(1'b1, 1'b0, 1'b0, 2, 324'(pack4(sol4))));
    @(negedge clk);
    board4_in = pack4(h);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    wait4("b2_multi_wait");

    repeat (3) @(negedge clk);
    chk("sb9_drained", exp9_q.size(), 0);
    chk("sb4_drained", exp4_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
